lcd_frame_receiver: RTL and testbench

//   Sink end of the LCD panel interface (NCLK/HD/VD/DEN/R/G/B).
//   - Measures each frame's geometry, checksums its active pixels and captures one probe pixel.
//   - Flags timing violations against the expected panel geometry.
//   - Sits beside the display generator as an on-chip monitor, or in benches as a self-checking panel model.

---
 rtl/lcd_frame_receiver.sv | 226 ++++++++++++++++++++++
 tb/tb_lcd_frame_receiver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_receiver.sv
// Sink-side monitor for an NCLK/HD/VD/DEN/RGB panel interface: measures frame geometry,
// checksums active pixels, captures one probe pixel and flags timing violations.
module lcd_frame_receiver #(
   parameter int H_ACTIVE    = 800,
   parameter int V_ACTIVE    = 480,
   parameter int PROBE_X     = 0,
   parameter int PROBE_Y     = 0,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        NCLK,
   input  logic        HD,
   input  logic        VD,
   input  logic        DEN,
   input  logic [7:0]  R,
   input  logic [7:0]  G,
   input  logic [7:0]  B,
   output logic        frame_done,
   output logic [10:0] active_w,
   output logic [9:0]  active_h,
   output logic [10:0] h_total,
   output logic [23:0] checksum,
   output logic [23:0] probe_rgb,
   output logic        frame_ok,
   output logic        line_err,
   output logic        timeout,
   output logic        locked
);

   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [10:0]     H_ACT   = 11'(H_ACTIVE);
   localparam logic [9:0]      V_ACT   = 10'(V_ACTIVE);
   localparam logic [10:0]     PX      = 11'(PROBE_X);
   localparam logic [9:0]      PY      = 10'(PROBE_Y);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

   typedef enum logic {IDLE, FRAME} state_t;

   state_t state_q, state_d;
   logic nclk_q, nclk_prev_q;
   logic hd_s_q, hd_s_d, vd_s_q, vd_s_d, den_s_q, den_s_d;
   logic [10:0] x_q, x_d, last_w_q, last_w_d, hcnt_q, hcnt_d, h_meas_q, h_meas_d;
   logic [9:0]  y_q, y_d;
   logic [23:0] sum_q, sum_d, probe_q, probe_d;
   logic        lerr_q, lerr_d, vsv_q, vsv_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic        frame_done_q, frame_done_d, frame_ok_q, frame_ok_d;
   logic        line_err_q, line_err_d, timeout_q, timeout_d;
   logic [10:0] active_w_q, active_w_d, h_total_q, h_total_d;
   logic [9:0]  active_h_q, active_h_d;
   logic [23:0] checksum_q, checksum_d, probe_rgb_q, probe_rgb_d;

   logic        strobe, vd_fall, hd_fall, den_eff, den_eff_prev, line_end;
   logic [23:0] rgb;

   // Pixels only count while VD is high, so DEN inside vertical sync is a violation, not a line.
   assign strobe       = nclk_q & ~nclk_prev_q;
   assign rgb          = {R, G, B};
   assign vd_fall      = vd_s_q & ~VD;
   assign hd_fall      = hd_s_q & ~HD;
   assign den_eff      = DEN & VD;
   assign den_eff_prev = den_s_q & vd_s_q;
   assign line_end     = den_eff_prev & ~den_eff;

   always_comb begin
      state_d      = state_q;
      hd_s_d       = hd_s_q;
      vd_s_d       = vd_s_q;
      den_s_d      = den_s_q;
      x_d          = x_q;
      y_d          = y_q;
      last_w_d     = last_w_q;
      hcnt_d       = hcnt_q;
      h_meas_d     = h_meas_q;
      sum_d        = sum_q;
      probe_d      = probe_q;
      lerr_d       = lerr_q;
      vsv_d        = vsv_q;
      wd_d         = wd_q;
      frame_done_d = 1'b0;
      active_w_d   = active_w_q;
      active_h_d   = active_h_q;
      h_total_d    = h_total_q;
      checksum_d   = checksum_q;
      probe_rgb_d  = probe_rgb_q;
      frame_ok_d   = frame_ok_q;
      line_err_d   = line_err_q;
      timeout_d    = timeout_q;

      if (strobe) begin
         hd_s_d  = HD;
         vd_s_d  = VD;
         den_s_d = DEN;
      end

      if (state_q == IDLE) begin
         wd_d = '0;
         if (strobe && vd_fall) begin
            state_d  = FRAME;
            x_d      = '0;
            y_d      = '0;
            last_w_d = '0;
            sum_d    = '0;
            probe_d  = '0;
            lerr_d   = 1'b0;
            vsv_d    = 1'b0;
            h_meas_d = '0;
            hcnt_d   = hd_fall ? 11'd1 : 11'd0;
         end
      end else if (strobe) begin
         wd_d = '0;
         if (den_eff) begin
            sum_d = sum_q + rgb;
            if (x_q == PX && y_q == PY) probe_d = rgb;
            if (x_q != 11'h7FF) x_d = x_q + 11'd1;
         end
         if (DEN && !VD) vsv_d = 1'b1;
         if (line_end) begin
            if (x_q != H_ACT) lerr_d = 1'b1;
            last_w_d = x_q;
            x_d      = '0;
            if (y_q != 10'h3FF) y_d = y_q + 10'd1;
         end
         if (hd_fall) begin
            h_meas_d = hcnt_q;
            hcnt_d   = 11'd1;
         end else if (hcnt_q != 11'h7FF) begin
            hcnt_d = hcnt_q + 11'd1;
         end
         // Frame close sees this strobe's line close but the pre-update HD measurement.
         if (vd_fall) begin
            active_w_d   = last_w_d;
            active_h_d   = y_d;
            checksum_d   = sum_d;
            probe_rgb_d  = probe_d;
            line_err_d   = lerr_d;
            frame_ok_d   = !lerr_d && (y_d == V_ACT) && !vsv_d;
            h_total_d    = h_meas_q;
            timeout_d    = 1'b0;
            frame_done_d = 1'b1;
            x_d          = '0;
            y_d          = '0;
            last_w_d     = '0;
            sum_d        = '0;
            probe_d      = '0;
            lerr_d       = 1'b0;
            vsv_d        = 1'b0;
         end
      end else if (wd_q == WD_LAST) begin
         state_d   = IDLE;
         timeout_d = 1'b1;
         wd_d      = '0;
      end else begin
         wd_d = wd_q + WD_W'(1);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= IDLE;
         nclk_q       <= 1'b0;
         nclk_prev_q  <= 1'b0;
         hd_s_q       <= 1'b1;
         vd_s_q       <= 1'b1;
         den_s_q      <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         last_w_q     <= '0;
         hcnt_q       <= '0;
         h_meas_q     <= '0;
         sum_q        <= '0;
         probe_q      <= '0;
         lerr_q       <= 1'b0;
         vsv_q        <= 1'b0;
         wd_q         <= '0;
         frame_done_q <= 1'b0;
         active_w_q   <= '0;
         active_h_q   <= '0;
         h_total_q    <= '0;
         checksum_q   <= '0;
         probe_rgb_q  <= '0;
         frame_ok_q   <= 1'b0;
         line_err_q   <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         nclk_q       <= NCLK;
         nclk_prev_q  <= nclk_q;
         hd_s_q       <= hd_s_d;
         vd_s_q       <= vd_s_d;
         den_s_q      <= den_s_d;
         x_q          <= x_d;
         y_q          <= y_d;
         last_w_q     <= last_w_d;
         hcnt_q       <= hcnt_d;
         h_meas_q     <= h_meas_d;
         sum_q        <= sum_d;
         probe_q      <= probe_d;
         lerr_q       <= lerr_d;
         vsv_q        <= vsv_d;
         wd_q         <= wd_d;
         frame_done_q <= frame_done_d;
         active_w_q   <= active_w_d;
         active_h_q   <= active_h_d;
         h_total_q    <= h_total_d;
         checksum_q   <= checksum_d;
         probe_rgb_q  <= probe_rgb_d;
         frame_ok_q   <= frame_ok_d;
         line_err_q   <= line_err_d;
         timeout_q    <= timeout_d;
      end
   end

   assign frame_done = frame_done_q;
   assign active_w   = active_w_q;
   assign active_h   = active_h_q;
   assign h_total    = h_total_q;
   assign checksum   = checksum_q;
   assign probe_rgb  = probe_rgb_q;
   assign frame_ok   = frame_ok_q;
   assign line_err   = line_err_q;
   assign timeout    = timeout_q;
   assign locked     = (state_q == FRAME);

endmodule

// File: tb/tb_lcd_frame_receiver.sv
// Directed bench for lcd_frame_receiver: table of frames with hand-computed results,
// plus watchdog-timeout and mid-line reset sequences.
module tb_lcd_frame_receiver;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic        rst, nclk, hd, vd, den;
   logic [7:0]  r, g, b;
   logic        frame_done, frame_ok, line_err, timeout, locked;
   logic [10:0] active_w, h_total;
   logic [9:0]  active_h;
   logic [23:0] checksum, probe_rgb;

   lcd_frame_receiver #(
      .H_ACTIVE(8), .V_ACTIVE(4), .PROBE_X(3), .PROBE_Y(2), .TIMEOUT_CYC(64)
   ) dut (
      .CLK(clk), .RST(rst), .NCLK(nclk), .HD(hd), .VD(vd), .DEN(den),
      .R(r), .G(g), .B(b),
      .frame_done(frame_done), .active_w(active_w), .active_h(active_h),
      .h_total(h_total), .checksum(checksum), .probe_rgb(probe_rgb),
      .frame_ok(frame_ok), .line_err(line_err), .timeout(timeout), .locked(locked)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Results captured on each frame_done pulse
   int          fd_count = 0;
   logic [10:0] cap_w, cap_ht;
   logic [9:0]  cap_h;
   logic [23:0] cap_sum, cap_probe;
   logic        cap_ok, cap_err, cap_to;

   always @(negedge clk) begin
      if (frame_done === 1'b1) begin
         fd_count++;
         cap_w     = active_w;
         cap_h     = active_h;
         cap_ht    = h_total;
         cap_sum   = checksum;
         cap_probe = probe_rgb;
         cap_ok    = frame_ok;
         cap_err   = line_err;
         cap_to    = timeout;
      end
   end

   // One NCLK period = 4 CLK; data changes with NCLK falling
   task automatic strobe(input logic h, input logic v, input logic d, input logic [23:0] px);
      @(posedge clk); #1;
      nclk = 1'b0; hd = h; vd = v; den = d; {r, g, b} = px;
      @(posedge clk); #1;
      nclk = 1'b1;
      @(posedge clk);
      @(posedge clk);
   endtask

   // 14-strobe line: 2 HD-low, 2 blank, npix active, rest blank
   task automatic line(input bit vd_low, input int npix, input int row, input bit pulse);
      for (int s = 0; s < 14; s++) begin
         logic        d;
         logic [7:0]  xb, yb;
         logic [23:0] px;
         d  = (s >= 4) && (s < 4 + npix);
         xb = 8'(s - 4);
         yb = 8'(row);
         px = d ? {xb, yb, 8'h01} : 24'h0;
         if (pulse && s == 5) begin
            d  = 1'b1;
            px = 24'h0;
         end
         strobe((s < 2) ? 1'b0 : 1'b1, ~vd_low, d, px);
      end
   endtask

   task automatic frame_body(input int w0, input int w1, input int w2, input int w3);
      line(0, 0, 0, 0);
      line(0, w0, 0, 0);
      line(0, w1, 1, 0);
      line(0, w2, 2, 0);
      line(0, w3, 3, 0);
      line(0, 0, 0, 0);
   endtask

   function automatic logic [23:0] model_sum(input int w0, input int w1, input int w2, input int w3);
      logic [23:0] s;
      int          w;
      s = 24'h0;
      for (int row = 0; row < 4; row++) begin
         w = (row == 0) ? w0 : (row == 1) ? w1 : (row == 2) ? w2 : w3;
         for (int x = 0; x < w; x++) s = s + {8'(x), 8'(row), 8'h01};
      end
      return s;
   endfunction

   typedef struct {
      string       name;
      int          w0, w1, w2, w3;
      bit          vsv;
      logic [10:0] exp_w;
      logic        exp_err;
      logic        exp_ok;
      logic [23:0] exp_probe;
   } vec_t;

   vec_t vecs [7];

   task automatic check_frame(input string name, input int fd_exp, input logic [23:0] sum_exp,
                              input logic [10:0] w_exp, input logic err_exp, input logic ok_exp,
                              input logic [23:0] probe_exp);
      check({name, ".frame_done_count"}, fd_count, fd_exp);
      check({name, ".active_w"}, cap_w, w_exp);
      check({name, ".active_h"}, cap_h, 10'd4);
      check({name, ".h_total"}, cap_ht, 11'd14);
      check({name, ".checksum"}, cap_sum, sum_exp);
      check({name, ".probe_rgb"}, cap_probe, probe_exp);
      check({name, ".line_err"}, cap_err, err_exp);
      check({name, ".frame_ok"}, cap_ok, ok_exp);
      check({name, ".timeout"}, cap_to, 1'b0);
      check({name, ".locked"}, locked, 1'b1);
      $display("frame %s: w=%0d h=%0d htot=%0d sum=%06h probe=%06h ok=%0b err=%0b",
               name, cap_w, cap_h, cap_ht, cap_sum, cap_probe, cap_ok, cap_err);
   endtask

   task automatic check_all_zero(input string name);
      check({name, ".frame_done"}, frame_done, 1'b0);
      check({name, ".active_w"}, active_w, 11'd0);
      check({name, ".active_h"}, active_h, 10'd0);
      check({name, ".h_total"}, h_total, 11'd0);
      check({name, ".checksum"}, checksum, 24'd0);
      check({name, ".probe_rgb"}, probe_rgb, 24'd0);
      check({name, ".frame_ok"}, frame_ok, 1'b0);
      check({name, ".line_err"}, line_err, 1'b0);
      check({name, ".timeout"}, timeout, 1'b0);
      check({name, ".locked"}, locked, 1'b0);
   endtask

   initial begin
      int fd_before;

      vecs[0] = '{"clean0",   8, 8, 8, 8, 1'b0, 11'd8, 1'b0, 1'b1, 24'h030201};
      vecs[1] = '{"clean1",   8, 8, 8, 8, 1'b0, 11'd8, 1'b0, 1'b1, 24'h030201};
      vecs[2] = '{"short1",   8, 7, 8, 8, 1'b0, 11'd8, 1'b1, 1'b0, 24'h030201};
      vecs[3] = '{"recover",  8, 8, 8, 8, 1'b0, 11'd8, 1'b0, 1'b1, 24'h030201};
      vecs[4] = '{"vsyncden", 8, 8, 8, 8, 1'b1, 11'd8, 1'b0, 1'b0, 24'h030201};
      vecs[5] = '{"lastw5",   8, 8, 8, 5, 1'b0, 11'd5, 1'b1, 1'b0, 24'h030201};
      vecs[6] = '{"noprobe",  8, 8, 2, 8, 1'b0, 11'd8, 1'b1, 1'b0, 24'h000000};

      rst = 1'b1; nclk = 1'b0; hd = 1'b1; vd = 1'b1; den = 1'b0; r = 8'h0; g = 8'h0; b = 8'h0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      repeat (3) strobe(1'b1, 1'b1, 1'b0, 24'h0);
      line(1, 0, 0, vecs[0].vsv);
      check("lock.locked", locked, 1'b1);
      check("lock.no_frame_done", fd_count, 0);

      for (int i = 0; i < 7; i++) begin
         fd_before = fd_count;
         frame_body(vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].w3);
         line(1, 0, 0, (i < 6) ? vecs[i + 1].vsv : 1'b0);
         check_frame(vecs[i].name, fd_before + 1,
                     model_sum(vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].w3),
                     vecs[i].exp_w, vecs[i].exp_err, vecs[i].exp_ok, vecs[i].exp_probe);
      end

      // NCLK stall mid-frame
      fd_before = fd_count;
      line(0, 0, 0, 0);
      line(0, 8, 0, 0);
      @(posedge clk); #1;
      nclk = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      check("stall.timeout", timeout, 1'b1);
      check("stall.locked", locked, 1'b0);
      check("stall.no_frame_done", fd_count, fd_before);
      $display("stall: timeout=%0b locked=%0b", timeout, locked);
      line(1, 0, 0, 0);
      check("relock.locked", locked, 1'b1);
      check("relock.timeout_held", timeout, 1'b1);
      check("relock.no_frame_done", fd_count, fd_before);
      frame_body(8, 8, 8, 8);
      line(1, 0, 0, 0);
      check_frame("after_stall", fd_before + 1, model_sum(8, 8, 8, 8), 11'd8, 1'b0, 1'b1, 24'h030201);
      check("after_stall.timeout_now", timeout, 1'b0);

      // Reset pulsed mid-line
      line(0, 0, 0, 0);
      strobe(1'b0, 1'b1, 1'b0, 24'h0);
      strobe(1'b0, 1'b1, 1'b0, 24'h0);
      strobe(1'b1, 1'b1, 1'b0, 24'h0);
      strobe(1'b1, 1'b1, 1'b0, 24'h0);
      for (int x = 0; x < 3; x++) strobe(1'b1, 1'b1, 1'b1, {8'(x), 8'h00, 8'h01});
      fd_before = fd_count;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check_all_zero("midreset");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) strobe(1'b1, 1'b1, 1'b0, 24'h0);
      line(1, 0, 0, 0);
      check("postreset.locked", locked, 1'b1);
      check("postreset.no_frame_done", fd_count, fd_before);
      frame_body(8, 8, 8, 8);
      line(1, 0, 0, 0);
      check_frame("postreset", fd_before + 1, model_sum(8, 8, 8, 8), 11'd8, 1'b0, 1'b1, 24'h030201);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
